// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared definitions for the register-file write-back path:
//               register address width, the x0 address, requester indices
//               and a small helper used by the write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int              REG_ADDR_W = 5;
    localparam logic [4:0]      ZERO_REG   = 5'd0;

    // Fixed requester slots on the write-back bus
    localparam int              REQ_ALU    = 0;
    localparam int              REQ_LOAD   = 1;
    localparam int              REQ_LINK   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // True when at least two bits of v are set: clearing the lowest set bit
    // leaves something behind only if more than one bit was set.
    function automatic logic more_than_one(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : Write-back request bus between the result sources and the
//               register-file write arbiter.
//               req_valid [NREQ]     requester i has a pending write
//               req_addr  [NREQ*5]   destination register, slice i = [5i+4:5i]
//               req_data  [NREQ*N]   write data, slice i = [Ni+N-1:Ni]
//               req_ready [NREQ]     one-hot grant back to the requesters
//               master : requester side, slave : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_write_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 3
) ();

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_addr;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface : rf_write_arbiter_if

`default_nettype wire

// File: rtl/rr_priority_encoder.sv
// ============================================================================
// Module      : rr_priority_encoder
// Description : Rotating priority encoder. Starting at index 'start' and
//               wrapping around, the first set bit of 'req' wins.
//               With start tied to 0 it is a plain lowest-index-wins encoder.
//               req     [NREQ]   request vector
//               start   [IDX_W]  index searched first
//               gnt     [NREQ]   one-hot grant (all zero if no request)
//               gnt_idx [IDX_W]  binary index of the granted bit
//               gnt_any          at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_encoder #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  wire logic [NREQ-1:0]  req,
    input  wire logic [IDX_W-1:0] start,
    output logic      [NREQ-1:0]  gnt,
    output logic      [IDX_W-1:0] gnt_idx,
    output logic                  gnt_any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            // start + k folded back into 0..NREQ-1 (start < NREQ, k < NREQ)
            idx = int'(start) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule : rr_priority_encoder

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the single register-file write port between NREQ
//               write-back requesters (ALU result, load data, jump link).
//               One request is granted per cycle; the winner's address and
//               data are registered onto RegWrite/WriteRegister/WriteData.
//               Writes to x0 are accepted but leave RegWrite low.
//               Build option WB_ARB_RR_EN: round-robin arbitration with a
//               rotating pointer; when undefined, lowest index wins.
// Ports       : clk            rising-edge clock
//               reset          asynchronous, active-low reset
//               wb (slave)     request bus: req_valid/addr/data in, req_ready out
//               RegWrite       registered write enable (0 for x0 or no grant)
//               WriteRegister  registered write address
//               WriteData      registered write data
//               conflict_cnt   saturating count of cycles with >=2 requests
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int N     = 32,
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    rf_write_arbiter_if.slave          wb,
    output logic                       RegWrite,
    output logic [REG_ADDR_W-1:0]      WriteRegister,
    output logic [N-1:0]               WriteData,
    output logic [CNT_W-1:0]           conflict_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0]      start_ptr;
    logic [NREQ-1:0]       gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    reg_addr_t             sel_addr;
    logic [N-1:0]          sel_data;
    logic                  multi_req;

    logic                  regwrite_q, regwrite_d;
    reg_addr_t             wr_addr_q,  wr_addr_d;
    logic [N-1:0]          wr_data_q,  wr_data_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef WB_ARB_RR_EN
    logic [IDX_W-1:0]      ptr_q, ptr_d;

    // Next search starts just past the last winner so every continuously
    // valid requester is reached within NREQ-1 cycles.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            if (int'(gnt_idx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start_ptr = ptr_q;
`else
    assign start_ptr = '0;
`endif

    rr_priority_encoder #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_enc (
        .req     (wb.req_valid),
        .start   (start_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // No handshake may complete while the block is held in reset
    assign wb.req_ready = reset ? gnt : '0;

    assign sel_addr  = wb.req_addr[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign sel_data  = wb.req_data[int'(gnt_idx)*N +: N];
    assign multi_req = more_than_one(8'(wb.req_valid));

    // ------------------------------------------------------------------
    // Write-back register and conflict counter
    // ------------------------------------------------------------------
    always_comb begin
        regwrite_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (gnt_any) begin
            // x0 is hard-wired to zero: take the request, suppress the write
            regwrite_d = (sel_addr != ZERO_REG);
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (multi_req && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign RegWrite      = regwrite_q;
    assign WriteRegister = wr_addr_q;
    assign WriteData     = wr_data_q;
    assign conflict_cnt  = cnt_q;

endmodule : rf_write_arbiter

`default_nettype wire
